// File: rtl/vga_line_fetch.sv
// vga_line_fetch: double-buffered scanline fetcher for a VGA controller.
// A Wishbone pipelined master reads LINE_WORDS 32-bit words per scanline into
// the back buffer. The display side reads the front buffer with one cycle of
// latency. The two buffers swap at each line boundary once the back buffer
// is complete.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   base_i                frame base byte address (word aligned)
//   frame_start_i         start-of-frame pulse: restart at line 0 from base_i
//   line_start_i          scanline boundary pulse: swap buffers, fetch next line
//   wb_*                  Wishbone pipelined read master
//   rd_addr_i/rd_data_o   front-buffer read port (registered data)
//   busy_o                a line fetch is in progress
//   underrun_o            line boundary arrived before the back buffer was full
module vga_line_fetch #(
  parameter int LINE_WORDS = 80,
  parameter int LINES      = 200,
  parameter int AW         = $clog2(LINE_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   base_i,
  input  logic          frame_start_i,
  input  logic          line_start_i,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [31:0]   wb_adr_o,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_stall_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o,
  output logic          busy_o,
  output logic          underrun_o
);
  localparam int CW = $clog2(LINE_WORDS + 1);
  localparam int LW = $clog2(LINES + 1);
  localparam logic [31:0] LINE_BYTES = 32'(4 * LINE_WORDS);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic            sel_q;       // 0: buf0 is front, 1: buf1 is front
  logic            trig_q;      // start a fetch from ptr_q on the next IDLE cycle
  logic            underrun_q;
  logic [31:0]     ptr_q;       // byte address of the next line to fetch
  logic [31:0]     adr_q;
  logic [31:0]     rd_data_q;
  logic [CW-1:0]   iss_cnt, ack_cnt;
  logic [LW-1:0]   line_cnt, line_nxt;

  logic [31:0] buf0 [LINE_WORDS];
  logic [31:0] buf1 [LINE_WORDS];

  logic req_acc, ack_ok, last_iss, last_ack, line_go;

  // frame_start_i overrides everything in its cycle, including acks and line_start_i
  assign req_acc  = (state_q == REQ) && !wb_stall_i && !frame_start_i;
  // counting against issued requests keeps a stray ack from running ahead
  assign ack_ok   = wb_ack_i && !frame_start_i && (ack_cnt < iss_cnt) &&
                    ((state_q == REQ) || (state_q == DRAIN));
  assign last_iss = req_acc && (iss_cnt == CW'(LINE_WORDS - 1));
  assign last_ack = ack_ok && (ack_cnt == CW'(LINE_WORDS - 1));
  assign line_go  = line_start_i && !frame_start_i;
  assign line_nxt = line_cnt + 1'b1;

  always_comb begin
    state_d = state_q;
    if (frame_start_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (trig_q)       state_d = REQ;
        REQ:     if (last_iss)     state_d = DRAIN;
        DRAIN:   if (last_ack)     state_d = DONE;
        DONE:    if (line_start_i) state_d = IDLE;
        default:                   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      trig_q     <= 1'b0;
      underrun_q <= 1'b0;
      ptr_q      <= '0;
      adr_q      <= '0;
      iss_cnt    <= '0;
      ack_cnt    <= '0;
      line_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      trig_q     <= 1'b0;
      underrun_q <= 1'b0;
      if (frame_start_i) begin
        ptr_q    <= base_i;
        line_cnt <= '0;
        iss_cnt  <= '0;
        ack_cnt  <= '0;
        trig_q   <= 1'b1;
      end else begin
        if (state_q == IDLE && trig_q) begin
          adr_q   <= ptr_q;
          iss_cnt <= '0;
          ack_cnt <= '0;
        end
        if (req_acc) begin
          adr_q   <= adr_q + 32'd4;
          iss_cnt <= iss_cnt + 1'b1;
        end
        if (ack_ok)   ack_cnt <= ack_cnt + 1'b1;
        if (last_ack) ptr_q   <= ptr_q + LINE_BYTES;
        if (line_go) begin
          if (state_q == DONE) begin
            sel_q    <= ~sel_q;
            line_cnt <= line_nxt;
            trig_q   <= (line_nxt < LW'(LINES));
          end else begin
            // back buffer incomplete: keep showing the old line, keep fetching
            underrun_q <= 1'b1;
          end
        end
      end
    end
  end

  // Back buffer is the one not selected as front.
  always_ff @(posedge clk_i) begin
    if (ack_ok) begin
      if (sel_q) buf0[ack_cnt[AW-1:0]] <= wb_dat_i;
      else       buf1[ack_cnt[AW-1:0]] <= wb_dat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      rd_data_q <= '0;
    else if (sel_q) rd_data_q <= buf1[rd_addr_i];
    else            rd_data_q <= buf0[rd_addr_i];
  end

  assign wb_cyc_o   = (state_q == REQ) || (state_q == DRAIN);
  assign wb_stb_o   = (state_q == REQ);
  assign wb_adr_o   = adr_q;
  assign wb_we_o    = 1'b0;
  assign wb_sel_o   = 4'hf;
  assign busy_o     = wb_cyc_o;
  assign underrun_o = underrun_q;
  assign rd_data_o  = rd_data_q;
endmodule

// File: doc/vga_line_fetch.md
VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 Parameter LINE_WORDS, default 80, 32-bit words fetched per scanline (320 px at 8 bpp).
REQ-002 Parameter LINES, default 200, scanlines fetched per frame.
REQ-003 Parameter AW, default $clog2(LINE_WORDS), read-port address width.
REQ-004 clk_i  in  1  system clock; all logic on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 base_i  in  32  frame base byte address, word-aligned.
REQ-007 frame_start_i  in  1  one-cycle pulse at start of frame (end of screen).
REQ-008 line_start_i  in  1  one-cycle pulse at each scanline boundary (end of line).
REQ-009 wb_cyc_o, wb_stb_o  out  1 each  Wishbone pipelined-master cycle and strobe.
REQ-010 wb_adr_o  out  32  byte address; wb_we_o out 1 (always 0); wb_sel_o out 4 (always 4'hf).
REQ-011 wb_dat_i  in  32, wb_ack_i  in  1, wb_stall_i  in  1  slave read data, acknowledge, stall.
REQ-012 rd_addr_i  in  AW  word index into the front (display) buffer.
REQ-013 rd_data_o  out  32  front-buffer word, registered.
REQ-014 busy_o  out  1  high while a line fetch is in progress.
REQ-015 underrun_o  out  1  one-cycle pulse when a line boundary arrives before the back buffer is complete.

Function
REQ-016 Two LINE_WORDS x 32 buffers; front is read via rd_addr_i, back is written by the fetcher; sel bit picks the front buffer.
REQ-017 rd_data_o = front[rd_addr_i] one cycle after rd_addr_i is presented (latency 1).
REQ-018 States: IDLE, REQ, DRAIN, DONE.
REQ-019 IDLE -> REQ when a fetch is triggered; cyc_o=1, stb_o=1 in REQ.
REQ-020 In REQ, a request is accepted on a cycle with stb_o & ~stall_i; wb_adr_o then advances by 4 and the issue count increments.
REQ-021 REQ -> DRAIN when the LINE_WORDS-th request is accepted; stb_o=0, cyc_o=1 in DRAIN.
REQ-022 Each ack_i writes wb_dat_i to back[ack count] and increments the ack count; acks are counted in REQ and DRAIN.
REQ-023 DRAIN -> DONE when the LINE_WORDS-th ack is received; cyc_o drops the same edge.
REQ-024 Acks never exceed issued requests; stray ack_i in IDLE or DONE is ignored.
REQ-025 frame_start_i: latch ptr=base_i; line count=0; abort any fetch (cyc_o/stb_o low next cycle, counts cleared); enter IDLE; trigger fetch of line 0 on the following cycle.
REQ-026 line_start_i in DONE: toggle sel; increment line count; if new count < LINES, trigger the next fetch from ptr; otherwise stay IDLE until frame_start_i.
REQ-027 line_start_i in IDLE, REQ or DRAIN: pulse underrun_o; no swap; the fetch continues; the completed line is swapped at the next line_start_i.
REQ-028 ptr advances by 4*LINE_WORDS at each fetch completion, so line n reads from base_i + 4*n*LINE_WORDS.
REQ-029 frame_start_i and line_start_i in the same cycle: frame_start_i wins; line_start_i is ignored.
REQ-030 busy_o = 1 in REQ and DRAIN.
REQ-031 Address arithmetic is modulo 2^32; wrap is not flagged.

Reset
REQ-032 On rst_i, asynchronously: state=IDLE; cyc_o=0; stb_o=0; wb_adr_o=0; rd_data_o=0; busy_o=0; underrun_o=0; sel=0; counts=0; ptr=0.
REQ-033 No fetch starts after reset until the first frame_start_i.
REQ-034 Buffer contents are not reset.

Verification
REQ-035 base_i=0x1000, frame_start pulse, zero-wait slave: 80 reads at 0x1000..0x113C; cyc_o drops after the 80th ack; busy_o falls.
REQ-036 Random stall_i and ack delays up to 5 cycles: address sequence unchanged; every word lands at the correct index; no ack is lost.
REQ-037 line_start after completion: sel toggles; rd_addr_i=5 returns word 5 of line 0 one cycle later; the line 1 fetch starts at 0x1140.
REQ-038 line_start while in DRAIN: underrun_o pulses once; no swap; the swap happens at the next line_start.
REQ-039 frame_start in mid REQ (30 issued): cyc_o low next cycle; refetch begins at the new base_i with counts at 0.
REQ-040 LINES=2: after the 2nd swap no further fetch occurs until frame_start; frame_start and line_start in the same cycle behave as frame_start only.
